// File: rtl/ecc_61_scrub_ctrl.sv
// rtl/ecc_61_scrub_ctrl.sv - background ECC scrubber: walks the array, counts errors, writes back correctable words
// Functional accesses always win; a started read/check/writeback completes unless reset intervenes.
module ecc_61_scrub_ctrl #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 61,
  parameter int PARITY_WIDTH = 8,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scrub_en,
  input  logic [15:0]             scrub_interval,
  input  logic                    func_req,
  input  logic                    clr_stat,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  input  logic [PARITY_WIDTH-1:0] mem_rd_parity,
  output logic [DATA_WIDTH-1:0]   dec_data_in,
  output logic [PARITY_WIDTH-1:0] dec_parity_in,
  input  logic [DATA_WIDTH-1:0]   dec_data_out,
  input  logic                    dec_sbit_err,
  input  logic                    dec_dbit_err,
  input  logic                    dec_ecc_fault,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic                    scrub_busy,
  output logic                    pass_done,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic                    dbit_irq
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_CHK,
    ST_WB,
    ST_NEXT
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             wait_cnt_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    pass_done_q;
  logic [CNT_WIDTH-1:0]    sbit_cnt_q, dbit_cnt_q, fault_cnt_q;
  logic [CNT_WIDTH-1:0]    sbit_cnt_d, dbit_cnt_d, fault_cnt_d;
  logic                    dbit_irq_q, dbit_irq_d;
  logic                    in_chk;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_chk = (state_q == ST_CHK);

  // A clear coincident with a check event resets first, then counts the event.
  always_comb begin
    logic [CNT_WIDTH-1:0] sbase, dbase, fbase;
    sbase      = clr_stat ? '0 : sbit_cnt_q;
    dbase      = clr_stat ? '0 : dbit_cnt_q;
    fbase      = clr_stat ? '0 : fault_cnt_q;
    sbit_cnt_d  = sbase;
    dbit_cnt_d  = dbase;
    fault_cnt_d = fbase;
    if (in_chk && dec_sbit_err)  sbit_cnt_d  = sat_inc(sbase);
    if (in_chk && dec_dbit_err)  dbit_cnt_d  = sat_inc(dbase);
    if (in_chk && dec_ecc_fault) fault_cnt_d = sat_inc(fbase);
    dbit_irq_d = (dbit_irq_q & ~clr_stat) | (in_chk & (dec_dbit_err | dec_ecc_fault));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wait_cnt_q  <= '0;
      wr_data_q   <= '0;
      pass_done_q <= 1'b0;
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
      dbit_irq_q  <= 1'b0;
    end else begin
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      dbit_irq_q  <= dbit_irq_d;
      pass_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (scrub_en) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= scrub_interval;
          end
        end
        ST_WAIT: begin
          if (!scrub_en) begin
            state_q <= ST_IDLE;
          end else if (wait_cnt_q == 16'd0) begin
            state_q <= ST_RD;
          end else begin
            wait_cnt_q <= wait_cnt_q - 16'd1;
          end
        end
        ST_RD: begin
          if (!func_req) state_q <= ST_CHK;
        end
        ST_CHK: begin
          // Only a correctable word with a trustworthy checker is rewritten.
          if (dec_sbit_err && !dec_ecc_fault) begin
            wr_data_q <= dec_data_out;
            state_q   <= ST_WB;
          end else begin
            state_q <= ST_NEXT;
          end
        end
        ST_WB: begin
          if (!func_req) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          addr_q      <= addr_q + 1'b1;
          pass_done_q <= (addr_q == {ADDR_WIDTH{1'b1}});
          if (scrub_en) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= scrub_interval;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are gated combinationally so a same-cycle functional request or reset suppresses them.
  assign mem_rd_en     = (state_q == ST_RD) && !func_req && !rst;
  assign mem_wr_en     = (state_q == ST_WB) && !func_req && !rst;
  assign mem_rd_addr   = addr_q;
  assign mem_wr_addr   = addr_q;
  assign mem_wr_data   = wr_data_q;
  assign dec_data_in   = in_chk ? mem_rd_data : '0;
  assign dec_parity_in = in_chk ? mem_rd_parity : '0;
  assign scrub_busy    = (state_q != ST_IDLE);
  assign pass_done     = pass_done_q;
  assign sbit_cnt      = sbit_cnt_q;
  assign dbit_cnt      = dbit_cnt_q;
  assign fault_cnt     = fault_cnt_q;
  assign dbit_irq      = dbit_irq_q;

endmodule

// File: tb/tb_ecc_61_scrub_ctrl.sv
// tb/tb_ecc_61_scrub_ctrl.sv - randomized self-checking bench for ecc_61_scrub_ctrl
// Memory and checker are modelled here; error kind per word is carried in the two low parity bits.
module tb_ecc_61_scrub_ctrl;
  localparam int AW = 6, DW = 61, PW = 8, CW = 8, DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst, scrub_en, func_req, clr_stat;
  logic [15:0]   scrub_interval;
  logic          mem_rd_en, mem_wr_en, scrub_busy, pass_done, dbit_irq;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, dec_data_in, dec_data_out, mem_wr_data;
  logic [PW-1:0] mem_rd_parity, dec_parity_in;
  logic          dec_sbit_err, dec_dbit_err, dec_ecc_fault;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;

  ecc_61_scrub_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
    .func_req(func_req), .clr_stat(clr_stat),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_parity(mem_rd_parity), .dec_data_in(dec_data_in), .dec_parity_in(dec_parity_in),
    .dec_data_out(dec_data_out), .dec_sbit_err(dec_sbit_err), .dec_dbit_err(dec_dbit_err),
    .dec_ecc_fault(dec_ecc_fault), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .scrub_busy(scrub_busy), .pass_done(pass_done),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .dbit_irq(dbit_irq)
  );

  always #5 clk = ~clk;

  // kind: 0 clean, 1 correctable, 2 double-bit, 3 checker fault (also flags sbit)
  logic [DW-1:0] mem_d [DEPTH];
  logic [5:0]    mem_h [DEPTH];
  logic [1:0]    kind  [DEPTH];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data   <= mem_d[mem_rd_addr];
      mem_rd_parity <= {mem_h[mem_rd_addr], kind[mem_rd_addr]};
    end
  end

  assign dec_sbit_err  = dec_parity_in[0];
  assign dec_dbit_err  = dec_parity_in[1] & ~dec_parity_in[0];
  assign dec_ecc_fault = &dec_parity_in[1:0];
  assign dec_data_out  = dec_sbit_err ? (dec_data_in ^ DW'(1)) : dec_data_in;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: expected address sequence, pending writeback, event tallies.
  int       n_rd = 0, n_wr = 0, pass_cnt = 0, exp_pass = 0;
  int       last_rd_cyc = 0, last_wr_cyc = 0, wr_lat = 0;
  int       last_rd_addr = 0, last_wr_addr = 0;
  int       viol = 0, dviol = 0, cviol = 0;
  int       m_sbit = 0, m_dbit = 0, m_fault = 0;
  logic     m_irq = 1'b0;
  int       exp_addr = 0, chk_addr = 0;
  bit       chk_pend = 0, wr_pend = 0;
  int       wr_addr = 0;
  logic [DW-1:0] wr_data;

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  always @(negedge clk) begin
    if ({sbit_cnt, dbit_cnt, fault_cnt, dbit_irq} !== {CW'(m_sbit), CW'(m_dbit), CW'(m_fault), m_irq})
      cviol++;
    if ((mem_rd_en && func_req) || (mem_wr_en && func_req) || (mem_rd_en && mem_wr_en))
      viol++;
    if (chk_pend) begin
      check("dec_data_in", dec_data_in, mem_d[chk_addr]);
      check("dec_parity_in", dec_parity_in, {mem_h[chk_addr], kind[chk_addr]});
    end else if (dec_data_in != '0 || dec_parity_in != '0) begin
      dviol++;
    end
    if (clr_stat) begin
      m_sbit = 0; m_dbit = 0; m_fault = 0; m_irq = 1'b0;
    end
    if (chk_pend) begin
      if (kind[chk_addr][0]) m_sbit = sat(m_sbit);
      if (kind[chk_addr] == 2'd2) m_dbit = sat(m_dbit);
      if (kind[chk_addr] == 2'd3) m_fault = sat(m_fault);
      if (kind[chk_addr][1]) m_irq = 1'b1;
      if (kind[chk_addr] == 2'd1) begin
        wr_pend = 1; wr_addr = chk_addr; wr_data = mem_d[chk_addr] ^ DW'(1);
      end
      chk_pend = 0;
    end
    if (mem_rd_en) begin
      check("rd_addr", mem_rd_addr, exp_addr);
      if (wr_pend) viol++;
      n_rd++; last_rd_cyc = cyc; last_rd_addr = mem_rd_addr;
      if (exp_addr == DEPTH - 1) exp_pass++;
      exp_addr = (exp_addr + 1) % DEPTH;
      chk_pend = 1; chk_addr = mem_rd_addr;
    end
    if (mem_wr_en) begin
      if (!wr_pend) viol++;
      else begin
        check("wr_addr", mem_wr_addr, wr_addr);
        check("wr_data", mem_wr_data, wr_data);
      end
      wr_pend = 0; n_wr++; last_wr_cyc = cyc; last_wr_addr = mem_wr_addr;
      wr_lat = cyc - last_rd_cyc;
    end
    if (pass_done) pass_cnt++;
    if (rst) begin
      m_sbit = 0; m_dbit = 0; m_fault = 0; m_irq = 1'b0;
      exp_addr = 0; wr_pend = 0; chk_pend = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pass(input int target, input int budget);
    int t = 0;
    while (pass_cnt < target && t < budget) begin tick(); t++; end
    check("pass_done_count", pass_cnt, target);
  endtask

  task automatic wait_reads(input int target, input int budget);
    int t = 0;
    while (n_rd < target && t < budget) begin tick(); t++; end
    check("read_count", n_rd, target);
  endtask

  // Returns in the CHK cycle of the next scrub read.
  task automatic wait_one_read(input string tag);
    int base = n_rd;
    int t = 0;
    while (n_rd == base && t < 100) begin tick(); t++; end
    check(tag, n_rd, base + 1);
  endtask

  task automatic pulse_clr();
    clr_stat = 1'b1; tick(); clr_stat = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int en_cyc, base_rd, base_wr, rel;
    rst = 1'b1; scrub_en = 1'b0; func_req = 1'b0; clr_stat = 1'b0; scrub_interval = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = DW'({$urandom(), $urandom()});
      mem_h[i] = 6'($urandom());
      kind[i]  = 2'd0;
    end
    repeat (3) tick();
    check("rst_busy", scrub_busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_pass_done", pass_done, 0);
    check("rst_counters", {sbit_cnt, dbit_cnt, fault_cnt, dbit_irq}, 0);
    check("rst_addr", mem_rd_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    rst = 1'b0;
    tick();

    // Clean pass, interval 2: first read four cycles after enable.
    scrub_interval = 16'd2; base_rd = n_rd; base_wr = n_wr;
    scrub_en = 1'b1; en_cyc = cyc;
    wait_reads(base_rd + 1, 20);
    check("first_rd_latency", last_rd_cyc - en_cyc, 4);
    check("first_rd_addr", last_rd_addr, 0);
    wait_pass(1, 1000);
    scrub_en = 1'b0;
    repeat (10) tick();
    check("clean_reads", n_rd - base_rd, 64);
    check("clean_writes", n_wr - base_wr, 0);
    check("clean_counters", {sbit_cnt, dbit_cnt, fault_cnt, dbit_irq}, 0);
    check("idle_busy", scrub_busy, 0);

    // Word 5 correctable, word 9 double-bit.
    kind[5] = 2'd1; kind[9] = 2'd2; base_wr = n_wr;
    scrub_interval = 16'($urandom_range(1, 3));
    scrub_en = 1'b1;
    wait_pass(2, 1000);
    scrub_en = 1'b0;
    repeat (5) tick();
    check("sbit_wb_count", n_wr - base_wr, 1);
    check("sbit_wb_addr", last_wr_addr, 5);
    check("sbit_wb_latency", wr_lat, 2);
    check("sbit_cnt_one", sbit_cnt, 1);
    check("dbit_cnt_one", dbit_cnt, 1);
    check("dbit_irq_sticky", dbit_irq, 1);
    pulse_clr();
    check("irq_after_clr", dbit_irq, 0);
    check("dbit_after_clr", dbit_cnt, 0);

    // Random error map, random functional traffic and clears.
    for (int i = 0; i < DEPTH; i++) begin
      int r = $urandom_range(0, 7);
      mem_d[i] = DW'({$urandom(), $urandom()});
      kind[i]  = 2'((r < 4) ? 0 : r - 4);
    end
    scrub_interval = 16'($urandom_range(0, 3));
    scrub_en = 1'b1;
    begin
      int t = 0;
      int target = pass_cnt + 2;
      while (pass_cnt < target && t < 5000) begin
        func_req = ($urandom_range(0, 9) < 3);
        clr_stat = ($urandom_range(0, 19) == 0);
        tick(); t++;
      end
      check("rand_pass_count", pass_cnt, target);
    end
    func_req = 1'b0; clr_stat = 1'b0; scrub_en = 1'b0;
    repeat (30) tick();
    check("rand_sbit_cnt", sbit_cnt, m_sbit);
    check("rand_dbit_cnt", dbit_cnt, m_dbit);
    check("rand_fault_cnt", fault_cnt, m_fault);
    check("rand_irq", dbit_irq, m_irq);
    check("rand_pass_vs_wrap", pass_cnt, exp_pass);

    // Functional priority while stalled in RD, then in WB.
    for (int i = 0; i < DEPTH; i++) kind[i] = 2'd1;
    scrub_interval = 16'd0; base_rd = n_rd;
    func_req = 1'b1; scrub_en = 1'b1;
    repeat (10) tick();
    check("rd_held_by_func", n_rd, base_rd);
    func_req = 1'b0; rel = cyc;
    tick();
    check("rd_resume_cycle", last_rd_cyc, rel);
    func_req = 1'b1; base_wr = n_wr;
    repeat (10) tick();
    check("wr_held_by_func", n_wr, base_wr);
    func_req = 1'b0; scrub_en = 1'b0; rel = cyc;
    tick();
    check("wr_resume_cycle", last_wr_cyc, rel);
    repeat (5) tick();

    // Saturation, then a clear landing on a CHK event.
    pulse_clr();
    scrub_en = 1'b1;
    wait_reads(n_rd + 300, 3000);
    scrub_en = 1'b0;
    repeat (10) tick();
    check("sbit_saturated", sbit_cnt, 255);
    scrub_en = 1'b1;
    wait_one_read("clr_chk_read");
    clr_stat = 1'b1; scrub_en = 1'b0;
    tick();
    clr_stat = 1'b0;
    check("clr_vs_event", sbit_cnt, 1);
    repeat (5) tick();

    // Reset while a writeback is held off by func_req.
    scrub_en = 1'b1;
    wait_one_read("rst_wb_read");
    func_req = 1'b1; base_wr = n_wr;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; func_req = 1'b0; scrub_en = 1'b0;
    check("rst_wb_busy", scrub_busy, 0);
    check("rst_wb_strobes", {mem_rd_en, mem_wr_en, pass_done}, 0);
    check("rst_wb_counters", {sbit_cnt, dbit_cnt, fault_cnt, dbit_irq}, 0);
    check("rst_wb_data", mem_wr_data, 0);
    repeat (3) tick();
    check("rst_wb_no_write", n_wr, base_wr);
    scrub_en = 1'b1;
    wait_reads(n_rd + 1, 50);
    check("post_rst_addr", last_rd_addr, 0);
    scrub_en = 1'b0;
    repeat (20) tick();

    check("strobe_violations", viol, 0);
    check("dec_idle_violations", dviol, 0);
    check("counter_track_violations", cviol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
